// File: rtl/booth_pkg.sv
// Shared types and sizing for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } booth_state_t;

    localparam int BOOTH_N = 4;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int booth_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_paso.sv
// One Booth iteration: conditional add/subtract of M, then arithmetic shift of {ACC, Q, Q-1}.
module booth_paso #(
    parameter int N = 4
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N:0]   m,
    output logic [N:0]   acc_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q_m1_nxt
);

    logic [N:0]     sum;
    logic [2*N+1:0] shifted;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // ACC MSB is replicated into the vacated top bit.
    assign shifted  = {sum[N], sum, q};
    assign acc_nxt  = shifted[2*N+1:N+1];
    assign q_nxt    = shifted[N:1];
    assign q_m1_nxt = shifted[0];

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: N iterations per signed NxN product, one-cycle done pulse.
module booth_mult
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = booth_cnt_w(N);

    booth_state_t   state, state_nxt;
    logic [N:0]     m, acc, acc_nxt;
    logic [N-1:0]   q, q_nxt;
    logic           q_m1, q_m1_nxt;
    logic [CW-1:0]  count;
    logic           last;

    assign last = (count == CW'(1));

    booth_paso #(.N(N)) u_paso (
        .acc      (acc),
        .q        (q),
        .q_m1     (q_m1),
        .m        (m),
        .acc_nxt  (acc_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid) state_nxt = CALC;
            CALC:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (valid) begin
                    m     <= {A[N-1], A};
                    q     <= B;
                    acc   <= '0;
                    q_m1  <= 1'b0;
                    count <= CW'(N);
                end
            end else begin
                acc   <= acc_nxt;
                q     <= q_nxt;
                q_m1  <= q_m1_nxt;
                count <= count - CW'(1);
                // The N+1-bit ACC top bit is only a sign guard; the product fits in 2N bits.
                if (last) begin
                    product <= {acc_nxt[N-1:0], q_nxt};
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult (N=4) with hand-computed products and cycle-accurate handshakes.
module tb_booth_mult;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic [N-1:0]   A, B;
    logic           busy, done;
    logic [2*N-1:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    booth_mult #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // valid in cycle 0; busy cycles 1..N; done and product in cycle N+1; done drops after.
    task automatic mult(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp);
        @(negedge clk);
        A = a; B = b; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            chk({tag, " busy"}, {14'd0, busy, done}, 16'b10);
            @(negedge clk);
        end
        chk({tag, " done"}, {14'd0, busy, done}, 16'b01);
        chk({tag, " product"}, {8'd0, product}, {8'd0, exp});
        @(negedge clk);
        chk({tag, " done drop"}, {14'd0, busy, done}, 16'b00);
        chk({tag, " held"}, {8'd0, product}, {8'd0, exp});
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; A = '0; B = '0;
        #12;
        chk("reset outs", {6'd0, busy, done, product}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        mult("3x2",   4'd3, 4'd2, 8'h06);
        mult("-8x-8", 4'h8, 4'h8, 8'h40);
        mult("7x-8",  4'd7, 4'h8, 8'hC8);
        mult("-1x-1", 4'hF, 4'hF, 8'h01);

        // Second valid while busy is ignored; a valid in the done cycle is accepted.
        @(negedge clk);
        A = 4'd5; B = 4'd3; valid = 1'b1;
        @(negedge clk);                       // cycle 1
        valid = 1'b0;
        @(negedge clk);                       // cycle 2
        A = 4'd2; B = 4'd2; valid = 1'b1;
        chk("ovl busy c2", {15'd0, busy}, 16'd1);
        @(negedge clk);                       // cycle 3
        valid = 1'b0; A = 4'd0; B = 4'd0;
        @(negedge clk);                       // cycle 4
        chk("ovl busy c4", {14'd0, busy, done}, 16'b10);
        @(negedge clk);                       // cycle 5
        chk("ovl done", {14'd0, busy, done}, 16'b01);
        chk("ovl product", {8'd0, product}, 16'h000F);
        A = 4'hD; B = 4'd4; valid = 1'b1;     // -3 * 4 = -12
        @(negedge clk);
        valid = 1'b0;
        chk("b2b busy", {14'd0, busy, done}, 16'b10);
        chk("b2b held", {8'd0, product}, 16'h000F);
        repeat (N - 1) @(negedge clk);
        chk("b2b busy end", {14'd0, busy, done}, 16'b10);
        @(negedge clk);
        chk("b2b done", {14'd0, busy, done}, 16'b01);
        chk("b2b product", {8'd0, product}, 16'h00F4);

        // Asynchronous reset in cycle 3 of a running multiply.
        @(negedge clk);
        A = 4'd3; B = 4'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);                       // cycle 3
        rst = 1'b1;
        #1;
        chk("rst mid busy", {15'd0, busy}, 16'd0);
        chk("rst mid done", {15'd0, done}, 16'd0);
        chk("rst mid product", {8'd0, product}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            @(negedge clk);
            chk("post rst idle", {14'd0, busy, done}, 16'b00);
        end
        chk("post rst product", {8'd0, product}, 16'h0000);

        mult("3x-3", 4'd3, 4'hD, 8'hF7);
        mult("0x-5", 4'd0, 4'hB, 8'h00);
        mult("-5x0", 4'hB, 4'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
